// File: rtl/fold_sig_pkg.sv
// Shared types and default widths for the folded-signature comparator.
package fold_sig_pkg;

  localparam int unsigned FSC_W     = 16;
  localparam int unsigned FSC_CNT_W = 8;

  typedef enum logic [1:0] {
    FSC_IDLE   = 2'd0,
    FSC_ACCUM  = 2'd1,
    FSC_RESULT = 2'd2
  } fsc_state_t;

endpackage

// File: rtl/fold_sig_cmp_if.sv
// Beat input channel and frame-result output channel of fold_sig_cmp.
interface fold_sig_cmp_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_aa;
  logic [W-1:0]     in_bb;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sig_a;
  logic [W-1:0]     out_sig_b;
  logic             out_match;
  logic [CNT_W-1:0] out_len;
  logic             out_len_sat;

  modport slave (
    input  in_valid, in_aa, in_bb, in_last, out_ready,
    output in_ready, out_valid, out_sig_a, out_sig_b, out_match, out_len, out_len_sat
  );

  modport master (
    output in_valid, in_aa, in_bb, in_last, out_ready,
    input  in_ready, out_valid, out_sig_a, out_sig_b, out_match, out_len, out_len_sat
  );

endinterface

// File: rtl/fold_sig_step.sv
// One signature update: rotate left by one, then XOR in the new folded word.
module fold_sig_step #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] sig_i,
  input  logic [W-1:0] word_i,
  output logic [W-1:0] sig_o
);

  assign sig_o = {sig_i[W-2:0], sig_i[W-1]} ^ word_i;

endmodule

// File: rtl/fold_sig_cmp.sv
// Accumulates rotate-XOR signatures of two folded streams per frame and compares them.
// Optional macro FOLD_SIG_CMP_STICKY_ERR_EN adds a sticky mismatch flag (err_sticky/err_clr).
module fold_sig_cmp
  import fold_sig_pkg::*;
#(
  parameter int unsigned W     = FSC_W,
  parameter int unsigned CNT_W = FSC_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  fold_sig_cmp_if.slave bus
`ifdef FOLD_SIG_CMP_STICKY_ERR_EN
  ,
  output logic err_sticky,
  input  logic err_clr
`endif
);

  localparam logic [1:0]       ST_IDLE   = 2'(FSC_IDLE);
  localparam logic [1:0]       ST_ACCUM  = 2'(FSC_ACCUM);
  localparam logic [1:0]       ST_RESULT = 2'(FSC_RESULT);
  localparam logic [CNT_W-1:0] LEN_MAX   = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic [W-1:0]     step_a, step_b;
  logic [CNT_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic             match_q, match_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept_c;
  logic             handshake_c;

  assign accept_c    = bus.in_valid && in_ready_q;
  assign handshake_c = out_valid_q && bus.out_ready;

  fold_sig_step #(.W(W)) u_step_a (.sig_i(sig_a_q), .word_i(bus.in_aa), .sig_o(step_a));
  fold_sig_step #(.W(W)) u_step_b (.sig_i(sig_b_q), .word_i(bus.in_bb), .sig_o(step_b));

  // Next-state and datapath; in_* are only looked at under accept_c.
  always_comb begin
    state_d = state_q;
    sig_a_d = sig_a_q;
    sig_b_d = sig_b_q;
    len_d   = len_q;
    sat_d   = sat_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          sig_a_d = bus.in_aa;
          sig_b_d = bus.in_bb;
          len_d   = CNT_W'(1);
          sat_d   = (len_d == LEN_MAX);
          match_d = (sig_a_d == sig_b_d);
          state_d = bus.in_last ? ST_RESULT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept_c) begin
          sig_a_d = step_a;
          sig_b_d = step_b;
          if (len_q != LEN_MAX) begin
            len_d = len_q + CNT_W'(1);
          end
          sat_d   = (len_d == LEN_MAX);
          match_d = (sig_a_d == sig_b_d);
          if (bus.in_last) begin
            state_d = ST_RESULT;
          end
        end
      end
      ST_RESULT: begin
        if (handshake_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d != ST_RESULT);
    out_valid_d = (state_d == ST_RESULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sig_a_q     <= '0;
      sig_b_q     <= '0;
      len_q       <= '0;
      sat_q       <= 1'b0;
      match_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_a_q     <= sig_a_d;
      sig_b_q     <= sig_b_d;
      len_q       <= len_d;
      sat_q       <= sat_d;
      match_q     <= match_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sig_a   = sig_a_q;
  assign bus.out_sig_b   = sig_b_q;
  assign bus.out_match   = match_q;
  assign bus.out_len     = len_q;
  assign bus.out_len_sat = sat_q;

`ifdef FOLD_SIG_CMP_STICKY_ERR_EN
  logic err_q, err_d;

  // A mismatching handshake overrides a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (handshake_c && !match_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: doc/fold_sig_cmp.md
FOLD_SIG_CMP -- requirements
Module: fold_sig_cmp

Interface
REQ-001 SHALL have parameter W, default 16, giving the width of each folded input word and each signature.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the beat counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: a folded word pair is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-007 SHALL have port in_aa, input, W bits: folded word of stream A, taken from the XOR-fold stage output aa.
REQ-008 SHALL have port in_bb, input, W bits: folded word of stream B, taken from the XOR-fold stage output bb.
REQ-009 SHALL have port in_last, input, 1 bit: the presented beat is the last beat of its frame.
REQ-010 SHALL have port out_valid, output, 1 bit: a frame result is held.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have ports out_sig_a and out_sig_b, output, W bits each: the frame signatures.
REQ-013 SHALL have port out_match, output, 1 bit: out_sig_a equals out_sig_b.
REQ-014 SHALL have port out_len, output, CNT_W bits: beats in the frame, saturating.
REQ-015 SHALL have port out_len_sat, output, 1 bit: the beat count saturated.

Function
REQ-016 SHALL implement an FSM with states IDLE, ACCUM and RESULT.
REQ-017 SHALL drive in_ready = 1 in IDLE and ACCUM, and in_ready = 0 in RESULT.
REQ-018 SHALL count a beat accepted only when in_valid && in_ready.
REQ-019 SHALL, on the first accepted beat of a frame (in IDLE), load sig_a = in_aa, sig_b = in_bb and len = 1.
REQ-020 SHALL, on each later accepted beat, update sig_x = rotl(sig_x, 1) ^ in_xx and len = len + 1.
REQ-021 SHALL hold len at 2^CNT_W-1 once it reaches that value and set len_sat; there is no wrap-around.
REQ-022 SHALL transition IDLE->ACCUM on an accepted beat with in_last=0, IDLE->RESULT on an accepted beat with in_last=1, and ACCUM->RESULT on an accepted beat with in_last=1.
REQ-023 SHALL assert out_valid the cycle after the last beat is accepted (latency 1) and compute out_match from the registered signatures.
REQ-024 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-025 SHALL move RESULT->IDLE on out_valid && out_ready; because in_ready is 0 in RESULT, no beat is accepted in that handoff cycle.
REQ-026 SHALL show no X-dependence on in_* while in_valid = 0.

Reset
REQ-027 SHALL, while rst_n = 0, set state = IDLE, in_ready = 1, out_valid = 0, out_sig_a = out_sig_b = 0, out_match = 0, out_len = 0 and out_len_sat = 0.
REQ-028 SHALL, on reset asserted mid-frame or in RESULT, discard the partial frame or pending result and leave no residue after reset is released.

Configuration
REQ-029 SHALL, with macro FOLD_SIG_CMP_STICKY_ERR_EN defined, add output err_sticky (1 bit) and input err_clr (1 bit).
REQ-030 SHALL, in that configuration, set err_sticky on each result handshake with out_match = 0, and clear it on err_clr; if both happen in the same cycle, set wins.
REQ-031 SHALL reset err_sticky to 0.
REQ-032 SHALL, with FOLD_SIG_CMP_STICKY_ERR_EN undefined, have neither port nor its logic, with all other behaviour identical.

Structure
REQ-033 SHALL define the FSM state enum (fsc_state_t) and the default W and CNT_W constants in shared package fold_sig_pkg.
REQ-034 SHALL place the rotate-XOR step in one sub-module, fold_sig_step (combinational, W-parameterised), instantiated twice (A and B).

Verification
REQ-035 SHALL cover: single beat aa=16'h1234, bb=16'h1234, last=1 -> next cycle out_valid=1, sig_a=sig_b=16'h1234, match=1, len=1.
REQ-036 SHALL cover: aa beats 16'h8001 then 16'h0001, bb beats 16'h0001 then 16'h8001 -> sig_a=16'h0002, sig_b=16'h8003, match=0, len=2.
REQ-037 SHALL cover: result pending with out_ready=0 for 5 cycles -> in_ready=0 and outputs stable throughout, then IDLE after the handshake.
REQ-038 SHALL cover: a 300-beat frame with CNT_W=8 -> len=255, len_sat=1.
REQ-039 SHALL cover: rst_n pulsed low after 3 beats of a frame -> all outputs at reset values, and the next 1-beat frame yields len=1.
REQ-040 SHALL cover (with STICKY_ERR_EN): a mismatching frame -> err_sticky=1; err_clr asserted together with a new mismatch handshake -> err_sticky stays 1.
